// File: rtl/div_unit.sv
// div_unit: iterative RV M-extension divider (DIV/DIVU/REM/REMU).
// Restoring division, one quotient bit per cycle; zero/overflow bypass.
module div_unit #(
    parameter int n = 64
) (
    input  logic         iCLK,
    input  logic         iRST,
    input  logic         iSTART,
    input  logic [1:0]   iOP,
    input  logic [n-1:0] iA,
    input  logic [n-1:0] iB,
    input  logic         iFLUSH,
    output logic         oBUSY,
    output logic         oDONE,
    output logic [n-1:0] oRESULT
);
    localparam int CW = $clog2(n) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t        state;
    logic          rsel;
    logic          qneg;
    logic          rneg;
    logic [CW-1:0] cnt;
    logic [n-1:0]  rem;
    logic [n-1:0]  quo;
    logic [n-1:0]  dvs;

    logic          sgn;
    logic          a_neg;
    logic          b_neg;
    logic          b_zero;
    logic          ovf;
    logic [n-1:0]  a_mag;
    logic [n-1:0]  b_mag;
    logic [n-1:0]  min_v;
    logic [n:0]    shl;
    logic [n:0]    diff;
    logic [n-1:0]  q_fix;
    logic [n-1:0]  r_fix;

    always_comb begin
        sgn    = ~iOP[0];
        a_neg  = sgn & iA[n-1];
        b_neg  = sgn & iB[n-1];
        a_mag  = a_neg ? ('0 - iA) : iA;
        b_mag  = b_neg ? ('0 - iB) : iB;
        min_v  = {1'b1, {(n-1){1'b0}}};
        b_zero = (iB == '0);
        ovf    = sgn & (iA == min_v) & (iB == '1);
        // n+1-bit partial remainder: shifted remainder plus next dividend bit
        shl    = {rem, quo[n-1]};
        diff   = shl - {1'b0, dvs};
        q_fix  = qneg ? ('0 - quo) : quo;
        r_fix  = rneg ? ('0 - rem) : rem;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state   <= IDLE;
            rsel    <= 1'b0;
            qneg    <= 1'b0;
            rneg    <= 1'b0;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            oBUSY   <= 1'b0;
            oDONE   <= 1'b0;
            oRESULT <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    oDONE <= 1'b0;
                    if (iSTART && !iFLUSH) begin
                        rsel  <= iOP[1];
                        qneg  <= a_neg ^ b_neg;
                        rneg  <= a_neg;
                        cnt   <= '0;
                        rem   <= '0;
                        quo   <= a_mag;
                        dvs   <= b_mag;
                        oBUSY <= 1'b1;
                        if (b_zero || ovf) begin
                            state <= DONE;
                            oDONE <= 1'b1;
                            unique case (1'b1)
                                b_zero && iOP[1]:  oRESULT <= iA;
                                b_zero && !iOP[1]: oRESULT <= '1;
                                !b_zero && iOP[1]: oRESULT <= '0;
                                default:           oRESULT <= min_v;
                            endcase
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (iFLUSH) begin
                        state <= IDLE;
                        oBUSY <= 1'b0;
                    end else begin
                        if (diff[n]) begin
                            rem <= shl[n-1:0];
                            quo <= {quo[n-2:0], 1'b0};
                        end else begin
                            rem <= diff[n-1:0];
                            quo <= {quo[n-2:0], 1'b1};
                        end
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(n - 1))
                            state <= FIX;
                    end
                end
                FIX: begin
                    if (iFLUSH) begin
                        state <= IDLE;
                        oBUSY <= 1'b0;
                    end else begin
                        oRESULT <= rsel ? r_fix : q_fix;
                        oDONE   <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    oBUSY <= 1'b0;
                    oDONE <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed + random checks of div_unit against an
// arithmetic reference model (RISC-V M-extension division rules).
module tb_div_unit;
    localparam int N = 64;
    localparam logic [N-1:0] MIN = {1'b1, {(N-1){1'b0}}};

    logic         iCLK;
    logic         iRST;
    logic         iSTART;
    logic [1:0]   iOP;
    logic [N-1:0] iA;
    logic [N-1:0] iB;
    logic         iFLUSH;
    logic         oBUSY;
    logic         oDONE;
    logic [N-1:0] oRESULT;

    int errors = 0;
    int checks = 0;
    logic [N-1:0] last_exp;

    div_unit #(.n(N)) dut (
        .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iOP(iOP),
        .iA(iA), .iB(iB), .iFLUSH(iFLUSH),
        .oBUSY(oBUSY), .oDONE(oDONE), .oRESULT(oRESULT)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [N-1:0] obs,
                       input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_fast(input logic [1:0] op,
                                   input logic [N-1:0] a, input logic [N-1:0] b);
        return (b == '0) || (!op[0] && a == MIN && b == '1);
    endfunction

    function automatic logic [N-1:0] model(input logic [1:0] op,
                                           input logic [N-1:0] a, input logic [N-1:0] b);
        if (b == '0)
            return op[1] ? a : '1;
        if (!op[0] && a == MIN && b == '1)
            return op[1] ? '0 : MIN;
        case (op)
            2'd0:    return $signed(a) / $signed(b);
            2'd1:    return a / b;
            2'd2:    return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [N-1:0] a, input logic [N-1:0] b,
                          input bit poke);
        int k;
        int lat;
        logic [N-1:0] e;
        e   = model(op, a, b);
        lat = is_fast(op, a, b) ? 1 : N + 2;
        iSTART = 1'b1; iOP = op; iA = a; iB = b;
        tick();
        iSTART = 1'b0;
        iA = ~a; iB = 64'd3;
        chk({tag, "_busy1"}, 64'(oBUSY), 64'd1);
        k = 1;
        while (!oDONE && k < 200) begin
            iSTART = (poke && k == 20);
            tick();
            k++;
        end
        iSTART = 1'b0;
        chk({tag, "_lat"}, 64'(k), 64'(lat));
        chk({tag, "_res"}, oRESULT, e);
        last_exp = e;
        tick();
        chk({tag, "_done0"}, 64'(oDONE), 64'd0);
        chk({tag, "_busy0"}, 64'(oBUSY), 64'd0);
        chk({tag, "_hold"}, oRESULT, e);
    endtask

    initial begin
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [1:0]   op;
        bit           seen;
        iRST = 1'b0; iSTART = 1'b0; iOP = 2'd0;
        iA = '0; iB = '0; iFLUSH = 1'b0;
        last_exp = '0;
        #2 iRST = 1'b1;
        #1;
        chk("rst_busy", 64'(oBUSY), 64'd0);
        chk("rst_done", 64'(oDONE), 64'd0);
        chk("rst_res", oRESULT, 64'd0);
        tick();
        tick();
        iRST = 1'b0;
        tick();

        run_op("divu_100_7", 2'd1, 64'd100, 64'd7, 1'b1);
        chk("divu_100_7_const", oRESULT, 64'd14);
        run_op("rem_m7_2", 2'd2, -64'sd7, 64'd2, 1'b0);
        chk("rem_m7_2_const", oRESULT, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("div_m7_2", 2'd0, -64'sd7, 64'd2, 1'b0);
        chk("div_m7_2_const", oRESULT, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_by0", 2'd0, 64'd5, 64'd0, 1'b0);
        chk("div_by0_const", oRESULT, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("remu_by0", 2'd3, 64'd5, 64'd0, 1'b0);
        chk("remu_by0_const", oRESULT, 64'd5);
        run_op("div_ovf", 2'd0, MIN, '1, 1'b0);
        chk("div_ovf_const", oRESULT, MIN);
        run_op("rem_ovf", 2'd2, MIN, '1, 1'b0);
        chk("rem_ovf_const", oRESULT, 64'd0);

        iSTART = 1'b1; iOP = 2'd1; iA = 64'd100; iB = 64'd7;
        tick();
        iSTART = 1'b0;
        repeat (9) tick();
        chk("flush_busy10", 64'(oBUSY), 64'd1);
        iFLUSH = 1'b1;
        tick();
        iFLUSH = 1'b0;
        chk("flush_busy11", 64'(oBUSY), 64'd0);
        chk("flush_done11", 64'(oDONE), 64'd0);
        chk("flush_res11", oRESULT, last_exp);
        seen = 1'b0;
        repeat (70) begin
            tick();
            if (oDONE) seen = 1'b1;
        end
        chk("flush_nodone", 64'(seen), 64'd0);
        run_op("remu_100_7", 2'd3, 64'd100, 64'd7, 1'b0);
        chk("remu_100_7_const", oRESULT, 64'd2);

        iSTART = 1'b1; iFLUSH = 1'b1; iOP = 2'd1; iA = 64'd9; iB = 64'd2;
        tick();
        iSTART = 1'b0; iFLUSH = 1'b0;
        chk("flush_prio_busy", 64'(oBUSY), 64'd0);
        chk("flush_prio_res", oRESULT, last_exp);

        iSTART = 1'b1; iOP = 2'd1; iA = 64'd12345; iB = 64'd67;
        tick();
        iSTART = 1'b0;
        repeat (29) tick();
        chk("mid_busy30", 64'(oBUSY), 64'd1);
        iRST = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(oBUSY), 64'd0);
        chk("mid_rst_done", 64'(oDONE), 64'd0);
        chk("mid_rst_res", oRESULT, 64'd0);
        tick();
        iRST = 1'b0;
        seen = 1'b0;
        repeat (70) begin
            tick();
            if (oDONE) seen = 1'b1;
        end
        chk("mid_rst_nodone", 64'(seen), 64'd0);
        run_op("post_rst", 2'd1, 64'd12345, 64'd67, 1'b0);

        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = {$urandom(), $urandom()};
            b  = {$urandom(), $urandom()};
            case (i % 4)
                1: begin
                    b = 64'($urandom_range(0, 9));
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                2: a = 64'($urandom_range(0, 1000));
                3: begin
                    a = MIN;
                    b = (i % 8 == 3) ? '1 : 64'($urandom_range(1, 5));
                end
                default: ;
            endcase
            run_op("rand", op, a, b, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
